ps2_scansw: RTL
===============

# ps2_scansw

PS/2 keyboard front end that produces the 21-bit `scanSW` key-state vector. The joystick/debounce stage merges that vector with the DB9 serial joysticks, active-high per key. The block receives set-2 scancode frames from the keyboard and filters the PS/2 clock. It tracks E0/F0/E1 prefixes and keeps held/toggle state for each mapped key. It sits between the board PS/2 pins and the joystick stage, in the `CLK_12M` domain.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, 12000: `CLK_12M` cycles with no filtered falling edge before a partial frame is discarded (1 ms).
- `CLK_12M`  in  1  system clock, 12 MHz; the only clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `PS2_CLK`  in  1  raw keyboard clock, asynchronous.
- `PS2_DATA`  in  1  raw keyboard data, asynchronous.
- `scanSW`  out  21  key state, 1 = pressed/on; bit map under Operation.
- `scan_valid`  out  1  one-cycle pulse per accepted byte.
- `scan_code`  out  8  last accepted byte; valid while `scan_valid` = 1, held otherwise.
- `frame_err`  out  1  one-cycle pulse on start, parity or stop error, or on timeout with at least one bit received.

## Operation
- **Input sync and filter**
  - 2-flop synchronisers on both PS/2 inputs.
  - Filtered clock starts at 1 and toggles only after `FILTER_LEN` consecutive opposite samples.
  - Data is sampled on a filtered 1→0 edge.
- **Frame receiver**, bit counter 0..10:
  - Frame is start(0), D0..D7 LSB first, odd parity, stop(1).
  - A bad start bit aborts the frame immediately and pulses `frame_err`.
  - A bad parity or stop bit discards the byte and pulses `frame_err`.
  - An idle counter reloads on every falling edge. When it reaches `TIMEOUT`, the bit counter returns to 0; a partial frame also pulses `frame_err`.
- **Decoder** states: IDLE, EXT (E0 seen), BRK (F0 seen, `ext` flag kept), SKIP (E1 Pause sequence).
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP with a 7-byte skip count; the next 7 bytes are dropped, then IDLE.
  - 00 or FF (overrun) → clear all held bits, keep bit 9, go to IDLE.
  - AA, FA, FE → ignored, go to IDLE.
  - Any other byte is a key: make if not in BRK, break if in BRK. Then go to IDLE.
  - `frame_err` resets the decoder to IDLE.
- **Key match**: the code and the extended flag must both match. E0 14 (right Ctrl) does not map to bit 4.
- **Held bits**: set on make, clear on break.
  - 0 up E0 75, 1 down E0 72, 2 left E0 6B, 3 right E0 74.
  - 4 fire1 14 (LCtrl), 5 fire2 11 (LAlt).
  - 6 F3 04, 7 F4 0C, 8 F5 03, 10 F6 0B.
  - 11 start1 16 ('1'), 12 start2 1E ('2'), 13 coin1 2E ('5').
  - 14 p2 up 2D (R), 15 p2 down 2B (F), 16 p2 left 23 (D), 17 p2 right 34 (G).
  - 18 p2 fire1 1C (A), 19 p2 fire2 1B (S), 20 coin2 36 ('6').
- **Bit 9, rotate toggle**, key F2 (06):
  - Inverts on a make only while the internal `f2_held` flag is 0. Typematic repeats therefore do not re-toggle.
  - `f2_held` clears on the F2 break.
  - Bit 9 is not cleared by 00/FF.

## Timing
- `RESET` forces `scanSW` = 0, `scan_valid` = 0, `scan_code` = 00, `frame_err` = 0, decoder IDLE, bit counter 0, filtered clock 1, `f2_held` = 0.
- Latency from the raw `PS2_CLK` stop-bit falling edge to the `scanSW` update:
  - 2 sync cycles + `FILTER_LEN` cycles + 1 cycle (`scan_valid` / `scan_code` registered) + 1 cycle (`scanSW` registered). Total 12 cycles at the default setting.
  - `scanSW` changes in the cycle after `scan_valid`.
- At most one byte is accepted per frame; `scan_valid` and `frame_err` are never high in the same cycle.
- `RESET` asserted mid-frame drops the frame silently; no `frame_err`.
- Make and break of the same key in consecutive frames produce a 1 followed by a 0; no coalescing.

## Configuration
- `PS2_P2_KEYS_EN` defined: bits 12 and 14–20 decode as listed.
- `PS2_P2_KEYS_EN` undefined: bits 12 and 14–20 are constant 0 and their codes are treated as unmapped. Receiver and decoder states are unchanged.

## Test plan
- **Make/break**: frame 14 → `scan_valid` pulse, `scan_code` = 14, `scanSW[4]` = 1 one cycle later; then frames F0,14 → `scanSW[4]` = 0.
- **Extended**: frames E0,75 → `scanSW[0]` = 1. Frames E0,14 → `scanSW[4]` stays 0. Frames E0,F0,75 → `scanSW[0]` = 0.
- **Toggle**: 06,06,06,F0,06,06 → bit 9 goes 0→1, stays 1 through the repeats, then returns to 0 on the second press.
- **Errors**: frame 16 with even parity → `frame_err` pulse, `scanSW[11]` stays 0. A 4-bit partial frame then 12000 idle cycles → `frame_err`; the next valid frame 16 sets `scanSW[11]`.
- **Pause and overrun**: E1,14,77,E1,F0,14,F0,77 → `scanSW` unchanged. With bits 0, 4 and 9 set, frame FF → `scanSW` = 0x000200.
- **Glitch and config**: 3-cycle low glitches on `PS2_CLK` → no bit counted. Without `PS2_P2_KEYS_EN`, frame 2D → `scanSW[14]` = 0.

Source files
------------

// File: rtl/ps2_scansw.sv
// ps2_scansw: PS/2 set-2 keyboard front end producing the 21-bit scanSW key-state vector.
//
// Raw PS2_CLK/PS2_DATA are synchronised, the clock is glitch-filtered, and 11-bit frames
// (start, D0..D7, odd parity, stop) are received on filtered falling edges. Accepted bytes
// drive a prefix decoder (E0/F0/E1) that updates held bits and the F2 rotate toggle (bit 9).
//
// Ports:
//   CLK_12M    in   1   system clock, 12 MHz
//   RESET      in   1   asynchronous, active-high reset
//   PS2_CLK    in   1   raw keyboard clock (asynchronous)
//   PS2_DATA   in   1   raw keyboard data (asynchronous)
//   scanSW     out  21  key state, 1 = pressed/on
//   scan_valid out  1   one-cycle pulse per accepted byte
//   scan_code  out  8   last accepted byte
//   frame_err  out  1   one-cycle pulse on start/parity/stop error or partial-frame timeout
//
// Build option: define PS2_P2_KEYS_EN to decode the player-2 keys (bits 12, 14-20);
// otherwise those bits stay 0 and their codes are unmapped.

module ps2_scansw #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 12000
) (
   input  logic        CLK_12M,
   input  logic        RESET,
   input  logic        PS2_CLK,
   input  logic        PS2_DATA,
   output logic [20:0] scanSW,
   output logic        scan_valid,
   output logic [7:0]  scan_code,
   output logic        frame_err
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW  = $clog2(TIMEOUT + 1);
   // Overrun keeps only the rotate toggle.
   localparam logic [20:0] SW_KEEP = 21'h000200;

   typedef enum logic [1:0] {StIdle, StExt, StBrk, StSkip} state_t;

   // ---------------------------------------------------------------- sync and filter
   logic [1:0]     r_clk_s;
   logic [1:0]     r_dat_s;
   logic           r_fclk;
   logic           r_fclk_q;
   logic [FCW-1:0] r_fcnt;
   logic           w_clk_sync;
   logic           w_dat;
   logic           w_fall;

   assign w_clk_sync = r_clk_s[1];
   assign w_dat      = r_dat_s[1];
   assign w_fall     = r_fclk_q & ~r_fclk;

   always_ff @(posedge CLK_12M or posedge RESET) begin
      if (RESET) begin
         r_clk_s  <= 2'b11;
         r_dat_s  <= 2'b11;
         r_fclk   <= 1'b1;
         r_fclk_q <= 1'b1;
         r_fcnt   <= '0;
      end else begin
         r_clk_s  <= {r_clk_s[0], PS2_CLK};
         r_dat_s  <= {r_dat_s[0], PS2_DATA};
         r_fclk_q <= r_fclk;
         // Filtered clock only follows after FILTER_LEN consecutive opposite samples.
         if (w_clk_sync != r_fclk) begin
            if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
               r_fclk <= w_clk_sync;
               r_fcnt <= '0;
            end else begin
               r_fcnt <= r_fcnt + 1'b1;
            end
         end else begin
            r_fcnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- frame receiver
   logic [3:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [TW-1:0] r_idle;
   logic          r_scan_valid;
   logic [7:0]    r_scan_code;
   logic          r_frame_err;

   always_ff @(posedge CLK_12M or posedge RESET) begin
      if (RESET) begin
         r_bitcnt     <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_idle       <= '0;
         r_scan_valid <= 1'b0;
         r_scan_code  <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_scan_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_fall) begin
            r_idle <= '0;
            if (r_bitcnt == 4'd0) begin
               if (!w_dat) r_bitcnt <= 4'd1;
               else        r_frame_err <= 1'b1;
            end else if (r_bitcnt <= 4'd8) begin
               r_shift  <= {w_dat, r_shift[7:1]};
               r_bitcnt <= r_bitcnt + 1'b1;
            end else if (r_bitcnt == 4'd9) begin
               r_par    <= w_dat;
               r_bitcnt <= 4'd10;
            end else begin
               r_bitcnt <= '0;
               // Odd parity: data plus parity bit must contain an odd number of ones.
               if (w_dat && (^{r_shift, r_par})) begin
                  r_scan_valid <= 1'b1;
                  r_scan_code  <= r_shift;
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
         end else if (r_idle == TW'(TIMEOUT)) begin
            // Saturated idle counter: drop any partial frame, flag it only once.
            r_bitcnt <= '0;
            if (r_bitcnt != 4'd0) r_frame_err <= 1'b1;
         end else begin
            r_idle <= r_idle + 1'b1;
         end
      end
   end

   assign scan_valid = r_scan_valid;
   assign scan_code  = r_scan_code;
   assign frame_err  = r_frame_err;

   // ---------------------------------------------------------------- key map
   // Returns {hit, bit index}; the extended flag is part of the match.
   function automatic logic [5:0] key_lookup(input logic ext, input logic [7:0] code);
      logic [5:0] res;
      res = '0;
      case ({ext, code})
         9'h175:  res = {1'b1, 5'd0};
         9'h172:  res = {1'b1, 5'd1};
         9'h16B:  res = {1'b1, 5'd2};
         9'h174:  res = {1'b1, 5'd3};
         9'h014:  res = {1'b1, 5'd4};
         9'h011:  res = {1'b1, 5'd5};
         9'h004:  res = {1'b1, 5'd6};
         9'h00C:  res = {1'b1, 5'd7};
         9'h003:  res = {1'b1, 5'd8};
         9'h00B:  res = {1'b1, 5'd10};
         9'h016:  res = {1'b1, 5'd11};
         9'h02E:  res = {1'b1, 5'd13};
`ifdef PS2_P2_KEYS_EN
         9'h01E:  res = {1'b1, 5'd12};
         9'h02D:  res = {1'b1, 5'd14};
         9'h02B:  res = {1'b1, 5'd15};
         9'h023:  res = {1'b1, 5'd16};
         9'h034:  res = {1'b1, 5'd17};
         9'h01C:  res = {1'b1, 5'd18};
         9'h01B:  res = {1'b1, 5'd19};
         9'h036:  res = {1'b1, 5'd20};
`endif
         default: res = '0;
      endcase
      return res;
   endfunction

   // ---------------------------------------------------------------- decoder
   state_t      r_state;
   state_t      w_state_d;
   logic        r_ext;
   logic        w_ext_d;
   logic [2:0]  r_skip;
   logic [2:0]  w_skip_d;
   logic        r_f2_held;
   logic        w_f2_d;
   logic [20:0] r_sw;
   logic [20:0] w_sw_d;
   logic [5:0]  w_key;
   logic [20:0] w_key_mask;
   logic        w_make;

   assign w_key      = key_lookup(r_ext, r_scan_code);
   assign w_key_mask = w_key[5] ? (21'd1 << w_key[4:0]) : 21'd0;
   assign w_make     = (r_state != StBrk);

   always_ff @(posedge CLK_12M or posedge RESET) begin
      if (RESET) begin
         r_state   <= StIdle;
         r_ext     <= 1'b0;
         r_skip    <= '0;
         r_f2_held <= 1'b0;
         r_sw      <= '0;
      end else begin
         r_state   <= w_state_d;
         r_ext     <= w_ext_d;
         r_skip    <= w_skip_d;
         r_f2_held <= w_f2_d;
         r_sw      <= w_sw_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_ext_d   = r_ext;
      w_skip_d  = r_skip;
      w_f2_d    = r_f2_held;
      w_sw_d    = r_sw;
      if (r_frame_err) begin
         w_state_d = StIdle;
         w_ext_d   = 1'b0;
         w_skip_d  = '0;
      end else if (r_scan_valid) begin
         if (r_state == StSkip) begin
            w_skip_d = r_skip - 1'b1;
            if (r_skip == 3'd1) w_state_d = StIdle;
         end else begin
            case (r_scan_code)
               8'hE0: begin
                  w_state_d = StExt;
                  w_ext_d   = 1'b1;
               end
               8'hF0: w_state_d = StBrk;
               8'hE1: begin
                  w_state_d = StSkip;
                  w_skip_d  = 3'd7;
                  w_ext_d   = 1'b0;
               end
               8'h00, 8'hFF: begin
                  w_sw_d    = r_sw & SW_KEEP;
                  w_state_d = StIdle;
                  w_ext_d   = 1'b0;
               end
               8'hAA, 8'hFA, 8'hFE: begin
                  w_state_d = StIdle;
                  w_ext_d   = 1'b0;
               end
               default: begin
                  if (!r_ext && (r_scan_code == 8'h06)) begin
                     // F2 toggles rotate once per press; typematic repeats are ignored.
                     if (w_make) begin
                        if (!r_f2_held) w_sw_d[9] = ~r_sw[9];
                        w_f2_d = 1'b1;
                     end else begin
                        w_f2_d = 1'b0;
                     end
                  end else if (w_make) begin
                     w_sw_d = r_sw | w_key_mask;
                  end else begin
                     w_sw_d = r_sw & ~w_key_mask;
                  end
                  w_state_d = StIdle;
                  w_ext_d   = 1'b0;
               end
            endcase
         end
      end
   end

   assign scanSW = r_sw;

endmodule
